hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Stall and forwarding controller for the five-stage MIPS pipeline. It decodes the D-stage instruction into source-operand use times (Tuse) and a destination register. It tracks destination and source registers of the E/M/W instructions internally, and compares them against the Tnew_E/Tnew_M values produced by the Tnew block. From this it generates the D-stage stall, the E-stage bubble, all forwarding-mux selects, and an MDU-busy stall for HI/LO instructions.

## Interface
- MULT_CYCLES, 5, E-stage busy cycles for MULT/MULTU
- DIV_CYCLES, 10, E-stage busy cycles for DIV/DIVU
- Clk  in  1  clock
- Rst  in  1  reset, synchronous, active-high
- Instr_D  in  32  instruction currently in D
- Tnew_E  in  2  cycles until E instruction's result exists; 0 for bubbles and non-writers
- Tnew_M  in  2  same, for M instruction
- Stall  out  1  freeze PC and F/D register
- Flush_E  out  1  load nop into D/E register (equals Stall)
- FwdRs_D, FwdRt_D  out  2  0 regfile, 1 from M, 2 from W, 3 from E (PC+8)
- FwdRs_E, FwdRt_E  out  2  0 pipeline value, 1 from M, 2 from W
- FwdRt_M  out  2  0 pipeline value, 2 from W (store data)

## Operation
- Tuse decode, D instr, 3 = unused, never stalls:
  - rs=0: BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, JR, JALR.
  - rs=1: R-type ALU except SLL/SRL/SRA; I-type ALU; loads; stores; MULT/MULTU/DIV/DIVU; MTHI/MTLO.
  - rt=0: BEQ, BNE.
  - rt=1: R-type ALU including SLL/SRL/SRA; MULT/MULTU/DIV/DIVU.
  - rt=2: SW, SB, SH, MTC0.
- Dest A3 decode:
  - rd: R-type ALU, shifts, MFHI, MFLO, JALR.
  - rt: I-type ALU, LUI, loads, MFC0.
  - 31: JAL.
  - 0: everything else.
- Internal regs: Rs_E, Rt_E, A3_E, Rt_M, A3_M, A3_W, MduCnt (4 bit).
- Data stall: for X in {rs, rt}, X≠0 and Tuse_X < 3, stall if either holds:
  - X==A3_E and Tuse_X < Tnew_E
  - X==A3_M and Tuse_X < Tnew_M
- MDU stall: D instr ∈ {MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO} and MduCnt≠0.
- Stall = data stall OR MDU stall; Flush_E = Stall.
- Register 0 never matches; A3=0 means no write.
- D forwarding, nearest first:
  - 3 if A3_E==X and Tnew_E==0.
  - else 1 if A3_M==X and Tnew_M==0.
  - else 2 if A3_W==X.
  - else 0.
- E forwarding (Rs_E, Rt_E): 1 if A3_M match and Tnew_M==0; else 2 if A3_W match; else 0.
- M forwarding (Rt_M): 2 if A3_W match; else 0.
- All forwarding selects are 0 when the source register is 0.

## Timing
- Outputs are combinational from Instr_D, Tnew inputs and internal regs; no extra latency.
- Each posedge, in order D→E→M→W:
  - E regs load the D decode, or 0 (bubble) when Stall=1.
  - Rt_M and A3_M load the E values.
  - A3_W loads A3_M.
  - M/W advance unconditionally.
- MduCnt:
  - Loads MULT_CYCLES or DIV_CYCLES at the edge a mult/div leaves D with Stall=0.
  - Otherwise decrements while ≠0.
  - Stalled D mult/div does not load.
- A MFLO directly after MULT stalls exactly MULT_CYCLES cycles.
- Rst, including mid-MDU-operation, clears all internal regs and MduCnt to 0 at the edge.
- Reset values: Stall=0, Flush_E=0, all Fwd=0, given Instr_D=0 and Tnew_E=Tnew_M=0.
- Simultaneous rs and rt hazards OR together; an MDU stall plus a data stall is a single Stall.

## Test plan
- lw $1,0($0); addu $2,$1,$3:
  - addu in D with Tnew_E=2: Stall=1 for one cycle.
  - Next cycle, Tnew_M=1: Stall=0.
  - addu in E: FwdRs_E=2.
- lw $1; beq $1,$0,L: Stall=1 for 2 cycles; then FwdRs_D=2 with lw in W.
- jal L; jr $31 with Tnew_E=0: Stall=0 and FwdRs_D=3.
- mult $4,$5; mflo $6: Stall=1 for exactly 5 cycles; a div then mfhi gives 10 cycles.
- lw $0; addu $2,$0,$0 and sw $1 after addu $1: no stall and all Fwd=0 for the $0 case; for the sw case, FwdRt_M=2 when sw is in M and addu in W.
- div in progress (MduCnt=7), assert Rst one cycle, then mflo: Stall=0 and all Fwd=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall and forwarding control for the five-stage MIPS pipeline: decodes the
// D-stage instruction, tracks E/M/W register usage and the HI/LO unit busy time.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Instr_D,
    input  logic [1:0]  Tnew_E,
    input  logic [1:0]  Tnew_M,
    output logic        Stall,
    output logic        Flush_E,
    output logic [1:0]  FwdRs_D,
    output logic [1:0]  FwdRt_D,
    output logic [1:0]  FwdRs_E,
    output logic [1:0]  FwdRt_E,
    output logic [1:0]  FwdRt_M
);

    logic [5:0] op_s, funct_s;
    logic [4:0] rs_s, rt_s, rd_s;
    logic       r_alu_s, shift_s, jr_s, jalr_s, mfhi_s, mflo_s, mthi_s, mtlo_s, muldiv_s, div_s;
    logic       branch_rs_s, beq_bne_s, i_alu_s, lui_s, load_s, store_s, mfc0_s, mtc0_s, jal_s;
    logic [1:0] tuse_rs_s, tuse_rt_s;
    logic [4:0] a3_d_s;
    logic       haz_rs_s, haz_rt_s, mdu_stall_s, stall_s;

    logic [4:0] rs_e_r, rt_e_r, a3_e_r, rt_m_r, a3_m_r, a3_w_r;
    logic [3:0] mdu_cnt_r;

    assign op_s    = Instr_D[31:26];
    assign rs_s    = Instr_D[25:21];
    assign rt_s    = Instr_D[20:16];
    assign rd_s    = Instr_D[15:11];
    assign funct_s = Instr_D[5:0];

    // Instruction class decode
    always_comb begin
        r_alu_s = 1'b0; shift_s = 1'b0; jr_s = 1'b0; jalr_s = 1'b0;
        mfhi_s = 1'b0; mflo_s = 1'b0; mthi_s = 1'b0; mtlo_s = 1'b0;
        muldiv_s = 1'b0; div_s = 1'b0;
        branch_rs_s = 1'b0; beq_bne_s = 1'b0; i_alu_s = 1'b0; lui_s = 1'b0;
        load_s = 1'b0; store_s = 1'b0; mfc0_s = 1'b0; mtc0_s = 1'b0; jal_s = 1'b0;
        case (op_s)
            6'h00: begin
                case (funct_s)
                    6'h00, 6'h02, 6'h03: shift_s = 1'b1;
                    6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: r_alu_s = 1'b1;
                    6'h08: jr_s = 1'b1;
                    6'h09: jalr_s = 1'b1;
                    6'h10: mfhi_s = 1'b1;
                    6'h11: mthi_s = 1'b1;
                    6'h12: mflo_s = 1'b1;
                    6'h13: mtlo_s = 1'b1;
                    6'h18, 6'h19: muldiv_s = 1'b1;
                    6'h1a, 6'h1b: begin
                        muldiv_s = 1'b1;
                        div_s    = 1'b1;
                    end
                    default: r_alu_s = 1'b0;
                endcase
            end
            6'h01, 6'h06, 6'h07: branch_rs_s = 1'b1;
            6'h03: jal_s = 1'b1;
            6'h04, 6'h05: begin
                branch_rs_s = 1'b1;
                beq_bne_s   = 1'b1;
            end
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: i_alu_s = 1'b1;
            6'h0f: lui_s = 1'b1;
            6'h10: begin
                mfc0_s = (rs_s == 5'd0);
                mtc0_s = (rs_s == 5'd4);
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: load_s = 1'b1;
            6'h28, 6'h29, 6'h2b: store_s = 1'b1;
            default: jal_s = 1'b0;
        endcase
    end

    // Operand use times and destination register of the D instruction
    always_comb begin
        tuse_rs_s = 2'd3;
        tuse_rt_s = 2'd3;
        a3_d_s    = 5'd0;
        if (branch_rs_s || jr_s || jalr_s) begin
            tuse_rs_s = 2'd0;
        end else if (r_alu_s || i_alu_s || load_s || store_s || muldiv_s || mthi_s || mtlo_s) begin
            tuse_rs_s = 2'd1;
        end else begin
            tuse_rs_s = 2'd3;
        end
        if (beq_bne_s) begin
            tuse_rt_s = 2'd0;
        end else if (r_alu_s || shift_s || muldiv_s) begin
            tuse_rt_s = 2'd1;
        end else if (store_s || mtc0_s) begin
            tuse_rt_s = 2'd2;
        end else begin
            tuse_rt_s = 2'd3;
        end
        if (r_alu_s || shift_s || mfhi_s || mflo_s || jalr_s) begin
            a3_d_s = rd_s;
        end else if (i_alu_s || lui_s || load_s || mfc0_s) begin
            a3_d_s = rt_s;
        end else if (jal_s) begin
            a3_d_s = 5'd31;
        end else begin
            a3_d_s = 5'd0;
        end
    end

    // Stall generation and forwarding selects
    always_comb begin
        haz_rs_s = (rs_s != 5'd0) && (tuse_rs_s != 2'd3) &&
                   (((rs_s == a3_e_r) && (tuse_rs_s < Tnew_E)) ||
                    ((rs_s == a3_m_r) && (tuse_rs_s < Tnew_M)));
        haz_rt_s = (rt_s != 5'd0) && (tuse_rt_s != 2'd3) &&
                   (((rt_s == a3_e_r) && (tuse_rt_s < Tnew_E)) ||
                    ((rt_s == a3_m_r) && (tuse_rt_s < Tnew_M)));
        mdu_stall_s = (muldiv_s || mfhi_s || mflo_s || mthi_s || mtlo_s) && (mdu_cnt_r != 4'd0);
        stall_s     = haz_rs_s || haz_rt_s || mdu_stall_s;
        Stall       = stall_s;
        Flush_E     = stall_s;
        FwdRs_D = fwd_d(rs_s, a3_e_r, a3_m_r, a3_w_r, Tnew_E, Tnew_M);
        FwdRt_D = fwd_d(rt_s, a3_e_r, a3_m_r, a3_w_r, Tnew_E, Tnew_M);
        FwdRs_E = fwd_e(rs_e_r, a3_m_r, a3_w_r, Tnew_M);
        FwdRt_E = fwd_e(rt_e_r, a3_m_r, a3_w_r, Tnew_M);
        if ((rt_m_r != 5'd0) && (rt_m_r == a3_w_r)) begin
            FwdRt_M = 2'd2;
        end else begin
            FwdRt_M = 2'd0;
        end
    end

    function automatic logic [1:0] fwd_d(input logic [4:0] src, input logic [4:0] a3e,
                                         input logic [4:0] a3m, input logic [4:0] a3w,
                                         input logic [1:0] tne, input logic [1:0] tnm);
        if (src == 5'd0)                        return 2'd0;
        else if ((src == a3e) && (tne == 2'd0)) return 2'd3;
        else if ((src == a3m) && (tnm == 2'd0)) return 2'd1;
        else if (src == a3w)                    return 2'd2;
        else                                    return 2'd0;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] src, input logic [4:0] a3m,
                                         input logic [4:0] a3w, input logic [1:0] tnm);
        if (src == 5'd0)                        return 2'd0;
        else if ((src == a3m) && (tnm == 2'd0)) return 2'd1;
        else if (src == a3w)                    return 2'd2;
        else                                    return 2'd0;
    endfunction

    // Pipeline register tracking and HI/LO busy counter
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rs_e_r    <= 5'd0;
            rt_e_r    <= 5'd0;
            a3_e_r    <= 5'd0;
            rt_m_r    <= 5'd0;
            a3_m_r    <= 5'd0;
            a3_w_r    <= 5'd0;
            mdu_cnt_r <= 4'd0;
        end else begin
            if (stall_s) begin
                rs_e_r <= 5'd0;
                rt_e_r <= 5'd0;
                a3_e_r <= 5'd0;
            end else begin
                rs_e_r <= rs_s;
                rt_e_r <= rt_s;
                a3_e_r <= a3_d_s;
            end
            rt_m_r <= rt_e_r;
            a3_m_r <= a3_e_r;
            a3_w_r <= a3_m_r;
            // A stalled mult/div is still waiting in D, so only a departing one arms the counter
            if (muldiv_s && !stall_s) begin
                mdu_cnt_r <= div_s ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            end else if (mdu_cnt_r != 4'd0) begin
                mdu_cnt_r <= mdu_cnt_r - 4'd1;
            end else begin
                mdu_cnt_r <= mdu_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed instruction sequences with
// hand-computed Stall/forwarding values checked by an independent monitor.
module tb_hazard_ctrl;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] Instr_D;
    logic [1:0]  Tnew_E, Tnew_M;
    logic        Stall, Flush_E;
    logic [1:0]  FwdRs_D, FwdRt_D, FwdRs_E, FwdRt_E, FwdRt_M;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk(Clk), .Rst(Rst), .Instr_D(Instr_D), .Tnew_E(Tnew_E), .Tnew_M(Tnew_M),
        .Stall(Stall), .Flush_E(Flush_E), .FwdRs_D(FwdRs_D), .FwdRt_D(FwdRt_D),
        .FwdRs_E(FwdRs_E), .FwdRt_E(FwdRt_E), .FwdRt_M(FwdRt_M)
    );

    always #5 Clk = ~Clk;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] LW1      = 32'h8C01_0000;
    localparam logic [31:0] LW0      = 32'h8C00_0000;
    localparam logic [31:0] ADDU213  = 32'h0023_1021;
    localparam logic [31:0] ADDU200  = 32'h0000_1021;
    localparam logic [31:0] ADDU123  = 32'h0043_0821;
    localparam logic [31:0] SW1      = 32'hAC01_0000;
    localparam logic [31:0] BEQ10    = 32'h1020_0004;
    localparam logic [31:0] JAL      = 32'h0C00_0010;
    localparam logic [31:0] JR31     = 32'h03E0_0008;
    localparam logic [31:0] MULT45   = 32'h0085_0018;
    localparam logic [31:0] DIV45    = 32'h0085_001A;
    localparam logic [31:0] MFLO6    = 32'h0000_3012;
    localparam logic [31:0] MFHI7    = 32'h0000_3810;

    typedef struct {
        string       name;
        logic [11:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    logic [11:0] act;
    logic        done = 1'b0;

    // Monitor: every issued vector is checked mid-cycle against its queued expectation
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e   = exp_q.pop_front();
            act = {Stall, Flush_E, FwdRs_D, FwdRt_D, FwdRs_E, FwdRt_E, FwdRt_M};
            n_total++;
            if (act === e.val) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got {Stall,Flush,RsD,RtD,RsE,RtE,RtM}=%b want %b",
                         e.name, act, e.val);
            end
        end
    end

    // Watchdog: fail if the directed sequence does not finish in time
    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout: sequence did not complete");
            $finish;
        end
    end

    task automatic step(input string name, input logic [31:0] instr,
                        input logic [1:0] tne, input logic [1:0] tnm,
                        input logic st, input logic [1:0] rsd, input logic [1:0] rtd,
                        input logic [1:0] rse, input logic [1:0] rte, input logic [1:0] rtm);
        exp_t e;
        Instr_D = instr;
        Tnew_E  = tne;
        Tnew_M  = tnm;
        e.name  = name;
        e.val   = {st, st, rsd, rtd, rse, rte, rtm};
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst     = 1'b1;
        Instr_D = NOP;
        Tnew_E  = 2'd0;
        Tnew_M  = 2'd0;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    // Directed stimulus sequence
    initial begin
        Rst = 1'b1; Instr_D = NOP; Tnew_E = 2'd0; Tnew_M = 2'd0;
        @(posedge Clk);
        #1;
        do_reset();
        n_total++;
        if ({Stall, Flush_E, FwdRs_D, FwdRt_D, FwdRs_E, FwdRt_E, FwdRt_M} === 12'd0) begin
            n_pass++;
        end else begin
            $display("FAIL reset_state: got {Stall,Flush,RsD,RtD,RsE,RtE,RtM}=%b want 0",
                     {Stall, Flush_E, FwdRs_D, FwdRt_D, FwdRs_E, FwdRt_E, FwdRt_M});
        end
        step("reset_idle", NOP, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);

        // lw $1 ; addu $2,$1,$3
        step("lw_issue",     LW1,     2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("addu_stall",   ADDU213, 2'd2, 2'd0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("addu_go",      ADDU213, 2'd0, 2'd1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("addu_E_fwdW",  NOP,     2'd1, 2'd0, 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0);

        // lw $1 ; beq $1,$0
        do_reset();
        step("lw_issue2",    LW1,     2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("beq_stall1",   BEQ10,   2'd2, 2'd0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("beq_stall2",   BEQ10,   2'd0, 2'd1, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("beq_fwdW",     BEQ10,   2'd0, 2'd0, 1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0);

        // jal ; jr $31
        do_reset();
        step("jal_issue",    JAL,     2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("jr_fwdE",      JR31,    2'd0, 2'd0, 1'b0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0);
        step("jr_E_fwdM",    NOP,     2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0);

        // mult ; mflo, then div ; mfhi
        do_reset();
        step("mult_issue",   MULT45,  2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        for (int i = 0; i < 5; i++)
            step($sformatf("mflo_busy%0d", i), MFLO6, 2'd0, 2'd0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("mflo_go",      MFLO6,   2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("div_issue",    DIV45,   2'd1, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        for (int i = 0; i < 10; i++)
            step($sformatf("mfhi_busy%0d", i), MFHI7, 2'd0, 2'd0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("mfhi_go",      MFHI7,   2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);

        // lw $0 ; addu $2,$0,$0 ; addu $1,$2,$3 ; sw $1
        do_reset();
        step("lw0_issue",    LW0,     2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("addu_r0",      ADDU200, 2'd2, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("addu1_issue",  ADDU123, 2'd1, 2'd1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("sw_no_stall",  SW1,     2'd1, 2'd0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0);
        step("sw_E_rt_fwdM", NOP,     2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0);
        step("sw_M_fwdW",    NOP,     2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2);

        // reset in the middle of a divide
        do_reset();
        step("div_issue2",   DIV45,   2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("mflo_in_div",  MFLO6,   2'd0, 2'd0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("div_nop1",     NOP,     2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("div_nop2",     NOP,     2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        do_reset();
        step("mflo_after_rst", MFLO6, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);

        @(posedge Clk);
        #1;
        done = 1'b1;
        if ((n_pass != n_total) || (exp_q.size() != 0)) begin
            $display("FAIL summary: %0d/%0d checks passed, %0d unchecked",
                     n_pass, n_total, exp_q.size());
        end else begin
            $display("PASS");
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
